// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the issue logic and the alu arbiter.
// The master is the issue side (requesters plus result consumer); the slave is the arbiter.
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_A0;
    logic [DATA_W-1:0] req_A1;
    logic [DATA_W-1:0] req_B0;
    logic [DATA_W-1:0] req_B1;
    logic [OP_W-1:0]   req_S0;
    logic [OP_W-1:0]   req_S1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_Q;
    logic              rsp_CMP;
    logic              rsp_id;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_A0, req_A1, req_B0, req_B1, req_S0, req_S1, rsp_ready,
        output req_ready, rsp_valid, rsp_Q, rsp_CMP, rsp_id, rsp_err
    );

    modport master (
        output req_valid, req_A0, req_A1, req_B0, req_B1, req_S0, req_S1, rsp_ready,
        input  req_ready, rsp_valid, rsp_Q, rsp_CMP, rsp_id, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational alu between two requesters.
// Operands are registered on the way into the alu, the result on the way out.
// One op in flight: IDLE (accept) -> EXEC (capture alu output) -> RESP (hold until taken).
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [OP_W-1:0]   alu_S,
    input  logic [DATA_W-1:0] alu_Q,
    input  logic              alu_CMP
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] alu_A_q, alu_A_d;
    logic [DATA_W-1:0] alu_B_q, alu_B_d;
    logic [OP_W-1:0]   alu_S_q, alu_S_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_Q_q, rsp_Q_d;
    logic              rsp_CMP_q, rsp_CMP_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_err_q, rsp_err_d;

    logic [1:0]        grant;
    logic [1:0]        req_ready;
    logic              accept;
    logic              capture;
    logic              rsp_done;
    logic              sel;

    // Round-robin pick: a lone requester always wins; on contention the port
    // that did not win last time goes first.
    always_comb begin
        grant = 2'b00;
        case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign sel = grant[1];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: one op walks IDLE -> EXEC -> RESP and returns once the result is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = EXEC;
            EXEC:                  state_d = RESP;
            RESP:    if (rsp_done) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE (and never while reset is held), capture in EXEC,
    // response handshake in RESP.
    always_comb begin
        req_ready = 2'b00;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = rst_n ? grant : 2'b00;
                accept    = rst_n & (|grant);
            end
            EXEC:    capture  = 1'b1;
            RESP:    rsp_done = rsp_valid_q & bus.rsp_ready;
            default: ;
        endcase
    end

    // Datapath next-state: operands load on accept and are held afterwards so the
    // alu inputs do not toggle while idle; illegal class (S[0]==0) zeroes the result.
    always_comb begin
        last_grant_d = last_grant_q;
        alu_A_d      = alu_A_q;
        alu_B_d      = alu_B_q;
        alu_S_d      = alu_S_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_Q_d      = rsp_Q_q;
        rsp_CMP_d    = rsp_CMP_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        if (accept) begin
            alu_A_d      = sel ? bus.req_A1 : bus.req_A0;
            alu_B_d      = sel ? bus.req_B1 : bus.req_B0;
            alu_S_d      = sel ? bus.req_S1 : bus.req_S0;
            last_grant_d = sel;
            rsp_id_d     = sel;
        end
        if (capture) begin
            rsp_err_d   = ~alu_S_q[0];
            rsp_Q_d     = alu_S_q[0] ? alu_Q : '0;
            rsp_CMP_d   = alu_S_q[0] & alu_CMP;
            rsp_valid_d = 1'b1;
        end
        if (rsp_done) rsp_valid_d = 1'b0;
    end

    // Datapath registers; reset discards any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            alu_A_q      <= '0;
            alu_B_q      <= '0;
            alu_S_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_Q_q      <= '0;
            rsp_CMP_q    <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            alu_A_q      <= alu_A_d;
            alu_B_q      <= alu_B_d;
            alu_S_q      <= alu_S_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_Q_q      <= rsp_Q_d;
            rsp_CMP_q    <= rsp_CMP_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_Q     = rsp_Q_q;
    assign bus.rsp_CMP   = rsp_CMP_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_err   = rsp_err_q;
    assign alu_A         = alu_A_q;
    assign alu_B         = alu_B_q;
    assign alu_S         = alu_S_q;

endmodule
